imem_fetch_controller: RTL

Sequencer for the word-addressed instruction memory: owns the PC, issues fetches, buffers returned words and hands them to decode over a valid/ready handshake. It also arbitrates the single memory port between program loading and fetching, supports branch/jump redirects and flags out-of-range fetches. It sits between the instruction memory and the decode stage of the MIPS core.

---
 rtl/imem_fetch_controller.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/imem_fetch_controller.sv
// imem_fetch_controller
// Owns the program counter of the MIPS core. It shares the single
// instruction-memory port between the program loader and the fetch engine.
// Fetched words are buffered in a 2-entry FIFO and handed to decode over a
// valid/ready handshake. Branch/jump redirects and halt flush the buffer and
// any read still in flight.
//
// Ports
//   clk, reset      : single clock; synchronous active-high reset
//   start, halt     : begin fetching at RESET_PC (IDLE) / stop and flush (RUN)
//   load_en/we/addr/data : program loader, active only in LOAD
//   mem_addr/re/we/wdata/rdata : memory port; read data arrives one cycle after mem_re
//   inst_valid/ready, inst, inst_pc : decode handshake, FIFO head
//   redirect_valid, redirect_pc : taken branch/jump target
//   fault           : sticky out-of-range fetch flag
//   state           : 0 IDLE, 1 LOAD, 2 RUN, 3 FAULT
module imem_fetch_controller #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        halt,
  input  logic        load_en,
  input  logic        load_we,
  input  logic [31:0] load_addr,
  input  logic [31:0] load_data,
  output logic [31:0] mem_addr,
  output logic        mem_re,
  output logic        mem_we,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        fault,
  output logic [1:0]  state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    RUN   = 2'd2,
    FAULT = 2'd3
  } state_t;

  localparam logic [31:0] DEPTH_WORDS = 32'(DEPTH);

  state_t      cur_state;
  state_t      next_state;
  logic [31:0] pc;
  logic [31:0] next_pc;
  logic [31:0] fifo_inst [2];
  logic [31:0] fifo_pc [2];
  logic        head;
  logic [1:0]  count;
  logic        inflight;
  logic [31:0] inflight_pc;

  logic        pop;
  logic        fill;
  logic        flush;
  logic        issue;
  logic        wr_idx;
  logic [2:0]  occupancy;
  logic        pc_in_range;
  logic        load_in_range;

  assign inst_valid    = (count != 2'd0);
  assign pop           = inst_valid & inst_ready;
  assign fill          = inflight & ~flush;
  assign wr_idx        = head ^ count[0];
  // Words still owed to decode after this cycle's handshake: buffered plus in flight.
  assign occupancy     = {1'b0, count} + {2'b00, inflight} - {2'b00, pop};
  assign pc_in_range   = (pc >> 2) < DEPTH_WORDS;
  assign load_in_range = (load_addr >> 2) < DEPTH_WORDS;
  assign fault         = (cur_state == FAULT);
  assign state         = cur_state;

  // The head is gated so that the outputs read zero while the buffer is empty.
  always_comb begin
    inst    = '0;
    inst_pc = '0;
    if (inst_valid) begin
      inst    = fifo_inst[head];
      inst_pc = fifo_pc[head];
    end
  end

  // Next-state, memory port and fetch-issue decisions.
  always_comb begin
    next_state = cur_state;
    next_pc    = pc;
    mem_addr   = '0;
    mem_re     = 1'b0;
    mem_we     = 1'b0;
    mem_wdata  = '0;
    flush      = 1'b0;
    issue      = 1'b0;
    unique case (cur_state)
      IDLE: begin
        if (load_en) begin
          next_state = LOAD;
        end else if (start) begin
          next_state = RUN;
          next_pc    = RESET_PC;
        end
      end
      LOAD: begin
        mem_addr  = load_addr & 32'hFFFF_FFFC;
        mem_wdata = load_data;
        mem_we    = load_we & load_in_range;
        if (!load_en) begin
          next_state = IDLE;
        end
      end
      RUN: begin
        if (halt) begin
          flush      = 1'b1;
          next_state = IDLE;
        end else if (redirect_valid) begin
          flush   = 1'b1;
          next_pc = redirect_pc & 32'hFFFF_FFFC;
        end else if (occupancy < 3'd2) begin
          if (pc_in_range) begin
            issue    = 1'b1;
            mem_re   = 1'b1;
            mem_addr = pc;
            next_pc  = pc + 32'd4;
          end else if (occupancy == 3'd0) begin
            // An out-of-range fetch is held back until every older word has
            // been handed to decode, so the fault is raised precisely after
            // the last legal instruction.
            flush      = 1'b1;
            next_state = FAULT;
          end
        end
      end
      FAULT: begin
        next_state = FAULT;
      end
    endcase
  end

  // State, PC and FIFO bookkeeping; a flush drops buffered words and the
  // pending read response together.
  always_ff @(posedge clk) begin
    if (reset) begin
      cur_state   <= IDLE;
      pc          <= RESET_PC;
      head        <= 1'b0;
      count       <= 2'd0;
      inflight    <= 1'b0;
      inflight_pc <= '0;
    end else begin
      cur_state <= next_state;
      pc        <= next_pc;
      if (flush) begin
        head     <= 1'b0;
        count    <= 2'd0;
        inflight <= 1'b0;
      end else begin
        head     <= head ^ pop;
        count    <= count + {1'b0, fill} - {1'b0, pop};
        inflight <= issue;
      end
      if (issue) begin
        inflight_pc <= pc;
      end
    end
  end

  // FIFO storage needs no reset because count gates every read of it.
  always_ff @(posedge clk) begin
    if (fill) begin
      fifo_inst[wr_idx] <= mem_rdata;
      fifo_pc[wr_idx]   <= inflight_pc;
    end
  end

endmodule
